// File: rtl/result_bcd_formatter.sv
// Converts one signed ALU result per handshake into sign, BCD magnitude and
// significant-digit count using an iterative shift-add-3 (one bit per clock).
module result_bcd_formatter #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_neg,
  output logic [4*DIGITS-1:0]          out_bcd,
  output logic [$clog2(DIGITS+1)-1:0]  out_ndig
);

  localparam int NDW   = $clog2(DIGITS + 1);
  localparam int CNT_W = $clog2(WIDTH + 1);

  // True when DIGITS decimal digits can hold the largest magnitude, 2**(WIDTH-1).
  function automatic bit digits_fit();
    longint p10;
    longint lim;
    p10 = 1;
    lim = longint'(1) << (WIDTH - 1);
    for (int i = 0; i < DIGITS; i++) begin
      p10 = p10 * 10;
      if (p10 > lim) return 1'b1;
    end
    return 1'b0;
  endfunction

  localparam bit DIGITS_OK = digits_fit();

  generate
    if (!DIGITS_OK) begin : g_bad_digits
      $error("result_bcd_formatter: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  neg_q, neg_d;

  logic                  out_valid_q, out_valid_d;
  logic                  out_neg_q, out_neg_d;
  logic [4*DIGITS-1:0]   out_bcd_q, out_bcd_d;
  logic [NDW-1:0]        out_ndig_q, out_ndig_d;

  logic [4*DIGITS-1:0]   bcd_adj;
  logic [NDW-1:0]        ndig_calc;

  // Add-3 correction applied to every digit before the shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    ndig_calc = NDW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) ndig_calc = NDW'(i + 1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    out_neg_d   = out_neg_q;
    out_bcd_d   = out_bcd_q;
    out_ndig_d  = out_ndig_q;
    in_ready    = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && in_ready) begin
          neg_d   = in_result[WIDTH-1];
          // Unsigned view of the negation keeps the most-negative value exact.
          mag_d   = in_result[WIDTH-1] ? (~in_result + WIDTH'(1)) : in_result;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_neg_d   = neg_q;
          out_bcd_d   = bcd_q;
          out_ndig_d  = ndig_calc;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_neg_q   <= 1'b0;
      out_bcd_q   <= '0;
      out_ndig_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      out_neg_q   <= out_neg_d;
      out_bcd_q   <= out_bcd_d;
      out_ndig_q  <= out_ndig_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_neg   = out_neg_q;
  assign out_bcd   = out_bcd_q;
  assign out_ndig  = out_ndig_q;

endmodule

// File: tb/tb_result_bcd_formatter.sv
// Randomized and directed checks of result_bcd_formatter against a decimal
// arithmetic reference model.
module tb_result_bcd_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_result;
  logic        out_valid;
  logic        out_ready;
  logic        out_neg;
  logic [23:0] out_bcd;
  logic [2:0]  out_ndig;

  int total = 0;
  int bad   = 0;

  result_bcd_formatter #(.WIDTH(20), .DIGITS(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_neg   (out_neg),
    .out_bcd   (out_bcd),
    .out_ndig  (out_ndig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: sign, magnitude digits by repeated division, digit count.
  function automatic void model(input logic [19:0] v, output logic n,
                                output logic [23:0] b, output logic [2:0] d);
    int s;
    int m;
    s = int'($signed(v));
    n = (s < 0);
    m = n ? -s : s;
    b = '0;
    d = 3'd1;
    for (int i = 0; i < 6; i++) begin
      if ((m % 10) != 0) d = 3'(i + 1);
      b[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // One full transfer; hold = cycles out_ready stays low after out_valid.
  task automatic xfer(input logic [19:0] v, input int hold, input bit junk);
    logic        en;
    logic [23:0] eb;
    logic [2:0]  ed;
    int          lat;
    model(v, en, eb, ed);
    wait_ready();
    in_valid  = 1'b1;
    in_result = v;
    @(negedge clk);
    in_valid  = junk;
    in_result = 20'($urandom);
    lat = 0;
    while (!out_valid && lat < 60) begin
      if (lat == 3) in_valid = 1'b0;
      if (lat == 5) chk("busy_rdy", {31'd0, in_ready}, 32'd0);
      out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
      in_result = 20'($urandom);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("latency", lat, 32'd21);
    chk("neg", {31'd0, out_neg}, {31'd0, en});
    chk("bcd", {8'd0, out_bcd}, {8'd0, eb});
    chk("ndig", {29'd0, out_ndig}, {29'd0, ed});
    $display("xfer in=%h neg=%0d bcd=%h ndig=%0d lat=%0d hold=%0d",
             v, out_neg, out_bcd, out_ndig, lat, hold);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_bcd", {8'd0, out_bcd}, {8'd0, eb});
      chk("hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drop_valid", {31'd0, out_valid}, 32'd0);
    chk("rdy_after", {31'd0, in_ready}, 32'd1);
    chk("kept_bcd", {8'd0, out_bcd}, {8'd0, eb});
  endtask

  initial begin
    logic        en;
    logic [23:0] eb;
    logic [2:0]  ed;
    logic [19:0] v;
    logic [19:0] nxt;
    int          lat;
    int          seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_result = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy", {31'd0, in_ready}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bcd", {8'd0, out_bcd}, 32'd0);
    chk("rst_ndig", {29'd0, out_ndig}, 32'd0);
    chk("rst_neg", {31'd0, out_neg}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rdy_post_rst", {31'd0, in_ready}, 32'd1);

    // Corners
    xfer(20'h00000, 0, 1'b0);
    xfer(20'hFFFF8, 1, 1'b1);
    xfer(20'h80000, 0, 1'b0);
    xfer(20'h7FFFF, 2, 1'b1);
    xfer(20'd1050, 5, 1'b0);

    // Randomized values: full range and small magnitudes of either sign
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) v = 20'($urandom);
      else v = 20'($signed($urandom_range(400)) - 200);
      xfer(v, int'($urandom_range(3)), 1'($urandom));
    end

    // Abort by reset in the middle of a conversion
    wait_ready();
    in_valid = 1'b1; in_result = 20'd99;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_valid0", {31'd0, out_valid}, 32'd0);
    chk("abort_bcd", {8'd0, out_bcd}, 32'd0);
    chk("abort_ndig", {29'd0, out_ndig}, 32'd0);
    chk("abort_rdy", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_pulse", seen, 32'd0);
    $display("abort in=00063 seen_valid=%0d", seen);
    xfer(20'd7, 0, 1'b0);

    // Back-to-back stream: in_valid and out_ready held high
    in_valid  = 1'b1;
    out_ready = 1'b1;
    v = 20'($urandom);
    for (int k = 0; k < 6; k++) begin
      model(v, en, eb, ed);
      in_result = v;
      wait_ready();
      @(negedge clk);
      nxt = 20'($urandom);
      in_result = nxt;
      lat = 0;
      while (!out_valid && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      chk("strm_latency", lat, 32'd21);
      chk("strm_neg", {31'd0, out_neg}, {31'd0, en});
      chk("strm_bcd", {8'd0, out_bcd}, {8'd0, eb});
      chk("strm_ndig", {29'd0, out_ndig}, {29'd0, ed});
      $display("stream in=%h neg=%0d bcd=%h ndig=%0d lat=%0d", v, out_neg, out_bcd, out_ndig, lat);
      @(negedge clk);
      chk("strm_pulse", {31'd0, out_valid}, 32'd0);
      chk("strm_rdy", {31'd0, in_ready}, 32'd1);
      v = nxt;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
